// File: rtl/fp_extremum_search_pkg.sv
// Shared definitions for the fixed-point extremum search.
//   - FSM state encodings of the search sequencer
//   - sign-bit position of a sign-magnitude word (bit N-1)
package fp_extremum_search_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  localparam int FP_N_DEFAULT = 32;
  localparam int SIGN_BIT     = FP_N_DEFAULT - 1;

  // Sign-bit index for an arbitrary word width n.
  function automatic int sign_bit_idx(input int n);
    return n - 1;
  endfunction

endpackage

// File: rtl/fp_extremum_search_fplessthan.sv
// fplessthan: combinational "a < b" on sign-magnitude fixed-point words.
//   Q  fractional bits (scale only; ordering does not depend on it)
//   N  word width, bit N-1 is the sign
// Ports:
//   a, b  in  N  operands
//   c     out 1  1 when a is strictly less than b
// -0 and +0 are distinct values; -0 orders below +0.
module fplessthan
  import fp_extremum_search_pkg::*;
#(
  parameter int Q = 15,
  parameter int N = 32
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         c
);

  localparam int SB = sign_bit_idx(N);

  // The binary point must sit inside the magnitude field.
  if (Q >= SB) begin : g_bad_q
    $error("fplessthan: Q must be smaller than N-1");
  end

  logic          sa;
  logic          sb;
  logic [SB-1:0] ma;
  logic [SB-1:0] mb;

  assign sa = a[SB];
  assign sb = b[SB];
  assign ma = a[SB-1:0];
  assign mb = b[SB-1:0];

  always_comb begin
    c = 1'b0;
    if (sa != sb) begin
      // Different signs: the negative operand is smaller (covers -0 < +0).
      c = sa;
    end else if (sa) begin
      // Both negative: larger magnitude is the smaller value.
      c = (ma > mb);
    end else begin
      c = (ma < mb);
    end
  end

endmodule

// File: rtl/fp_extremum_search.sv
// fp_extremum_search: streams COUNT words from a 1-cycle-latency RAM through a
// single shared fplessthan comparator and returns the minimum or maximum value
// together with its offset in the streamed block.
// Ports:
//   clk, rst           clock (rising edge), asynchronous active-low reset
//   start              1-cycle request pulse, accepted only in IDLE
//   find_max           0 = minimum, 1 = maximum (latched at start)
//   base_addr, count   block start address and length (latched at start)
//   rd_en, rd_addr     RAM read strobe / address; rd_data valid one cycle later
//   rd_data            RAM read data
//   busy               search in progress
//   done               1-cycle pulse, result valid
//   empty              with done: block length was zero
//   ext_val, ext_idx   extremum value and offset, held until the next start
//   dbg_state          current FSM state
// Handshake: start is a request with no ready; it is honoured only when the
// sequencer is in IDLE and otherwise dropped. done is a single-cycle valid.
module fp_extremum_search
  import fp_extremum_search_pkg::*;
#(
  parameter int Q  = 15,
  parameter int N  = 32,
  parameter int AW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          find_max,
  input  logic [AW-1:0] base_addr,
  input  logic [AW-1:0] count,
  output logic          rd_en,
  output logic [AW-1:0] rd_addr,
  input  logic [N-1:0]  rd_data,
  output logic          busy,
  output logic          done,
  output logic          empty,
  output logic [N-1:0]  ext_val,
  output logic [AW-1:0] ext_idx,
  output logic [1:0]    dbg_state
);

  logic [1:0]    state;
  logic [1:0]    state_nxt;
  logic          max_q;
  logic [AW-1:0] base_q;
  logic [AW-1:0] count_q;
  logic [AW:0]   issue_cnt;
  logic          pipe_vld;
  logic [AW-1:0] pipe_idx;
  logic          empty_q;
  logic [N-1:0]  ext_val_q;
  logic [AW-1:0] ext_idx_q;
  logic [N-1:0]  cmp_a;
  logic [N-1:0]  cmp_b;
  logic          cmp_c;
  logic          start_ok;
  logic          last_issue;

  assign start_ok   = (state == ST_IDLE) && start;
  assign last_issue = ((issue_cnt + 1'b1) == {1'b0, count_q});

  always_comb begin
    state_nxt = state;
    case (state)
      // A zero-length search still passes through DRAIN so done always
      // arrives count+2 cycles after the accepted start.
      ST_IDLE:  if (start) state_nxt = (count == '0) ? ST_DRAIN : ST_ISSUE;
      ST_ISSUE: if (last_issue) state_nxt = ST_DRAIN;
      ST_DRAIN: state_nxt = ST_DONE;
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Min: update when new < current. Max: update when current < new.
  // Strict compare keeps the lowest index on ties in both modes.
  assign cmp_a = max_q ? ext_val_q : rd_data;
  assign cmp_b = max_q ? rd_data   : ext_val_q;

  fplessthan #(.Q(Q), .N(N)) u_cmp (
    .a (cmp_a),
    .b (cmp_b),
    .c (cmp_c)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_IDLE;
      max_q     <= 1'b0;
      base_q    <= '0;
      count_q   <= '0;
      issue_cnt <= '0;
      pipe_vld  <= 1'b0;
      pipe_idx  <= '0;
      empty_q   <= 1'b0;
      ext_val_q <= '0;
      ext_idx_q <= '0;
    end else begin
      state <= state_nxt;
      // Valid/index travel alongside the RAM read latency.
      pipe_vld <= (state == ST_ISSUE);
      pipe_idx <= issue_cnt[AW-1:0];
      if (start_ok) begin
        max_q     <= find_max;
        base_q    <= base_addr;
        count_q   <= count;
        issue_cnt <= '0;
        empty_q   <= (count == '0);
        ext_val_q <= '0;
        ext_idx_q <= '0;
      end else if (state == ST_ISSUE) begin
        issue_cnt <= issue_cnt + 1'b1;
      end
      // Element 0 seeds the running extremum unconditionally.
      if (pipe_vld && ((pipe_idx == '0) || cmp_c)) begin
        ext_val_q <= rd_data;
        ext_idx_q <= pipe_idx;
      end
    end
  end

  assign rd_en     = (state == ST_ISSUE);
  assign rd_addr   = base_q + issue_cnt[AW-1:0];
  assign busy      = (state == ST_ISSUE) || (state == ST_DRAIN);
  assign done      = (state == ST_DONE);
  assign empty     = done && empty_q;
  assign ext_val   = ext_val_q;
  assign ext_idx   = ext_idx_q;
  assign dbg_state = state;

endmodule
